// File: rtl/rate_limiter_multi_regs.sv
// rtl/rate_limiter_multi_regs.sv - Multi-channel rate limiter register node on the UDP register ring
//
// Configures and monitors NUM_CHANNELS rate limiters. Each channel owns four
// words: ENABLE (off 0), SHIFT (off 1), DROP_COUNT (off 2), INFO (off 3).
// Ring requests not served here are forwarded with one cycle of latency.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reg_*_in / reg_*_out        register ring input and registered output
//   drop_pulse[c]               one-cycle pulse per packet dropped by channel c
//   enable_rate_limit[c]        channel c ENABLE bit
//   thruput_shift[16c+15:16c]   channel c SHIFT value
`ifndef RATE_LIMIT_0_BLOCK_ADDR
`define RATE_LIMIT_0_BLOCK_ADDR 15'h0001
`endif

module rate_limiter_multi_regs #(
    parameter int UDP_REG_SRC_WIDTH  = 2,
    parameter int UDP_REG_ADDR_WIDTH = 23,
    parameter int DATA_WIDTH         = 32,
    parameter int REG_ADDR_WIDTH     = 8,
    parameter logic [UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_TAG = `RATE_LIMIT_0_BLOCK_ADDR,
    parameter int NUM_CHANNELS       = 4,
    parameter int CLEAR_ON_READ      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reg_req_in,
    input  logic                          reg_ack_in,
    input  logic                          reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [DATA_WIDTH-1:0]         reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
    output logic                          reg_req_out,
    output logic                          reg_ack_out,
    output logic                          reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic [DATA_WIDTH-1:0]         reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out,
    input  logic [NUM_CHANNELS-1:0]       drop_pulse,
    output logic [NUM_CHANNELS-1:0]       enable_rate_limit,
    output logic [16*NUM_CHANNELS-1:0]    thruput_shift
);
    localparam int CH_W      = REG_ADDR_WIDTH - 2;
    localparam int NUM_SLOTS = 2 ** CH_W;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CHANNELS);

    logic [CH_W-1:0]       ch;
    logic [1:0]            off;
    logic                  tag_hit;
    logic                  serve;
    logic                  ch_ok;
    logic                  is_wr;
    logic [DATA_WIDTH-1:0] rd_word;

    // Read-side views of every addressable channel slot; slots beyond
    // NUM_CHANNELS read as zero so the mux index never leaves the array.
    logic        en_arr    [0:NUM_SLOTS-1];
    logic [15:0] shift_arr [0:NUM_SLOTS-1];
    logic [31:0] cnt_arr   [0:NUM_SLOTS-1];

    assign ch      = reg_addr_in[REG_ADDR_WIDTH-1:2];
    assign off     = reg_addr_in[1:0];
    assign tag_hit = (reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BLOCK_TAG);
    assign serve   = reg_req_in && tag_hit && !reg_ack_in;
    assign ch_ok   = ({1'b0, ch} < NUM_CH_L);
    assign is_wr   = !reg_rd_wr_L_in;

    for (genvar c = 0; c < NUM_SLOTS; c++) begin : g_ch
        if (c < NUM_CHANNELS) begin : g_real
            logic        sel;
            logic        clr;
            logic        en_q;
            logic [15:0] shift_q;
            logic [31:0] drop_cnt;
            logic [31:0] cnt_nxt;

            assign sel = serve && ch_ok && (ch == CH_W'(c));
            assign clr = sel && (off == 2'd2) && (is_wr || (CLEAR_ON_READ != 0));

            // A clear loads the coincident pulse so a drop in the clear cycle is kept.
            always_comb begin
                cnt_nxt = drop_cnt;
                if (clr) begin
                    cnt_nxt = {31'b0, drop_pulse[c]};
                end else if (drop_pulse[c] && (drop_cnt != 32'hFFFF_FFFF)) begin
                    cnt_nxt = drop_cnt + 32'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    en_q     <= 1'b0;
                    shift_q  <= 16'h0;
                    drop_cnt <= 32'h0;
                end else begin
                    if (sel && is_wr && (off == 2'd0)) en_q    <= reg_data_in[0];
                    if (sel && is_wr && (off == 2'd1)) shift_q <= reg_data_in[15:0];
                    drop_cnt <= cnt_nxt;
                end
            end

            assign en_arr[c]    = en_q;
            assign shift_arr[c] = shift_q;
            assign cnt_arr[c]   = drop_cnt;
            assign enable_rate_limit[c]   = en_q;
            assign thruput_shift[16*c +: 16] = shift_q;
        end else begin : g_pad
            assign en_arr[c]    = 1'b0;
            assign shift_arr[c] = 16'h0;
            assign cnt_arr[c]   = 32'h0;
        end
    end

    // Pre-write value of the addressed word, or the bad-channel marker.
    always_comb begin
        rd_word = '0;
        case (off)
            2'd0:    rd_word[0]    = en_arr[ch];
            2'd1:    rd_word[15:0] = shift_arr[ch];
            2'd2:    rd_word[31:0] = cnt_arr[ch];
            default: rd_word[31:0] = 32'(NUM_CHANNELS);
        endcase
        if (!ch_ok) begin
            rd_word       = '0;
            rd_word[31:0] = 32'hdead_beef;
        end
    end

    // Address, source and direction are forwarded even during reset.
    always_ff @(posedge clk) begin
        reg_addr_out    <= reg_addr_in;
        reg_src_out     <= reg_src_in;
        reg_rd_wr_L_out <= reg_rd_wr_L_in;
        if (reset) begin
            reg_req_out  <= 1'b0;
            reg_ack_out  <= 1'b0;
            reg_data_out <= '0;
        end else begin
            reg_req_out <= reg_req_in;
            if (serve) begin
                reg_ack_out  <= 1'b1;
                reg_data_out <= rd_word;
            end else begin
                reg_ack_out  <= reg_ack_in;
                reg_data_out <= reg_data_in;
            end
        end
    end
endmodule

// File: tb/tb_rate_limiter_multi_regs.sv
// tb/tb_rate_limiter_multi_regs.sv - Self-checking bench for rate_limiter_multi_regs
module tb_rate_limiter_multi_regs;
    localparam int NCH = 4;
    localparam logic [14:0] TAG = 15'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_i, ack_i, rw_i;
    logic [22:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  src_i;
    logic [3:0]  pulse;

    logic        req_o  [2];
    logic        ack_o  [2];
    logic        rw_o   [2];
    logic [22:0] addr_o [2];
    logic [31:0] data_o [2];
    logic [1:0]  src_o  [2];
    logic [3:0]  en_o   [2];
    logic [63:0] sh_o   [2];

    rate_limiter_multi_regs #(.BLOCK_TAG(TAG), .NUM_CHANNELS(NCH), .CLEAR_ON_READ(0)) dut0 (
        .clk(clk), .reset(reset), .reg_req_in(req_i), .reg_ack_in(ack_i), .reg_rd_wr_L_in(rw_i),
        .reg_addr_in(addr_i), .reg_data_in(data_i), .reg_src_in(src_i),
        .reg_req_out(req_o[0]), .reg_ack_out(ack_o[0]), .reg_rd_wr_L_out(rw_o[0]),
        .reg_addr_out(addr_o[0]), .reg_data_out(data_o[0]), .reg_src_out(src_o[0]),
        .drop_pulse(pulse), .enable_rate_limit(en_o[0]), .thruput_shift(sh_o[0]));

    rate_limiter_multi_regs #(.BLOCK_TAG(TAG), .NUM_CHANNELS(NCH), .CLEAR_ON_READ(1)) dut1 (
        .clk(clk), .reset(reset), .reg_req_in(req_i), .reg_ack_in(ack_i), .reg_rd_wr_L_in(rw_i),
        .reg_addr_in(addr_i), .reg_data_in(data_i), .reg_src_in(src_i),
        .reg_req_out(req_o[1]), .reg_ack_out(ack_o[1]), .reg_rd_wr_L_out(rw_o[1]),
        .reg_addr_out(addr_o[1]), .reg_data_out(data_o[1]), .reg_src_out(src_o[1]),
        .drop_pulse(pulse), .enable_rate_limit(en_o[1]), .thruput_shift(sh_o[1]));

    // Reference state: index 0 models CLEAR_ON_READ=0, index 1 models CLEAR_ON_READ=1.
    logic        m_en  [2][NCH];
    logic [15:0] m_sh  [2][NCH];
    longint      m_cnt [2][NCH];
    logic        e_req;
    logic        e_ack  [2];
    logic [31:0] e_data [2];
    logic [22:0] e_addr;
    logic [1:0]  e_src;
    logic        e_rw;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [22:0] mk_addr(input int ch, input int off);
        return {TAG, 6'(ch), 2'(off)};
    endfunction

    // Drive one cycle of inputs, predict the registered outputs, wait past the edge.
    task automatic step(input logic rst, input logic rq, input logic ak, input logic rw,
                        input logic [22:0] a, input logic [31:0] d, input logic [3:0] p);
        int  chn, of;
        bit  srv, clr;
        longint sum;
        reset = rst; req_i = rq; ack_i = ak; rw_i = rw; addr_i = a; data_i = d;
        src_i = 2'($urandom); pulse = p;
        chn = int'(a[7:2]);
        of  = int'(a[1:0]);
        srv = rq && (a[22:8] == TAG) && !ak;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_ack[k] = 1'b0; e_data[k] = 32'h0;
                for (int c = 0; c < NCH; c++) begin
                    m_en[k][c] = 1'b0; m_sh[k][c] = 16'h0; m_cnt[k][c] = 0;
                end
            end else begin
                if (!srv) begin
                    e_ack[k] = ak; e_data[k] = d;
                end else begin
                    e_ack[k] = 1'b1;
                    if (chn >= NCH) e_data[k] = 32'hdead_beef;
                    else begin
                        case (of)
                            0: e_data[k] = m_en[k][chn] ? 32'd1 : 32'd0;
                            1: e_data[k] = {16'h0, m_sh[k][chn]};
                            2: e_data[k] = 32'(m_cnt[k][chn]);
                            default: e_data[k] = NCH;
                        endcase
                        if (!rw && of == 0) m_en[k][chn] = d[0];
                        if (!rw && of == 1) m_sh[k][chn] = d[15:0];
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    clr = srv && chn == c && of == 2 && (!rw || k == 1);
                    sum = m_cnt[k][c] + longint'(p[c]);
                    if (clr) m_cnt[k][c] = longint'(p[c]);
                    else m_cnt[k][c] = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum;
                end
            end
        end
        e_req = rst ? 1'b0 : rq;
        e_addr = a; e_src = src_i; e_rw = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b0, 1'b0, mk_addr(0, 0), 32'h1, 4'hF);
        step(1'b1, 1'b1, 1'b0, 1'b0, mk_addr(0, 0), 32'h1, 4'hF);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (req_o[k] !== 1'b0 || ack_o[k] !== 1'b0 || data_o[k] !== 32'h0 || en_o[k] !== 4'h0 || sh_o[k] !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_outs[%0d] req=%b ack=%b data=%h en=%h sh=%h want all 0", k, req_o[k], ack_o[k], data_o[k], en_o[k], sh_o[k]);
            end
            n_cmp++;
            if (addr_o[k] !== mk_addr(0, 0) || src_o[k] !== e_src) begin
                n_bad++;
                $display("FAIL reset_pass[%0d] addr=%h src=%h want %h %h", k, addr_o[k], src_o[k], mk_addr(0, 0), e_src);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(0, 2), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_cnt[%0d] ack=%b data=%h want 1 0", k, ack_o[k], data_o[k]);
            end
        end
    endtask

    task automatic test_config;
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_addr(2, 0), 32'hFFFF_FFFF, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (en_o[k] !== 4'b0100) begin
                n_bad++; $display("FAIL cfg_enable[%0d] got %b want 0100", k, en_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_addr(2, 1), 32'hABCD_0005, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (sh_o[k][47:32] !== 16'h0005 || sh_o[k][31:0] !== 32'h0) begin
                n_bad++; $display("FAIL cfg_shift[%0d] got %h want 0005 in ch2 only", k, sh_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(2, 0), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'h1) begin
                n_bad++; $display("FAIL rd_enable[%0d] ack=%b data=%h want 1 1", k, ack_o[k], data_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(2, 1), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'h5) begin
                n_bad++; $display("FAIL rd_shift[%0d] ack=%b data=%h want 1 5", k, ack_o[k], data_o[k]);
            end
        end
    endtask

    task automatic test_drop_count;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, mk_addr(0, 0), 32'h0, 4'b0010);
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(1, 2), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (data_o[k] !== 32'd10) begin
                n_bad++; $display("FAIL drop_read1[%0d] got %0d want 10", k, data_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(1, 2), 32'h0, 4'h0);
        n_cmp++;
        if (data_o[0] !== 32'd10) begin
            n_bad++; $display("FAIL drop_read2_keep got %0d want 10", data_o[0]);
        end
        n_cmp++;
        if (data_o[1] !== 32'd0) begin
            n_bad++; $display("FAIL drop_read2_clr got %0d want 0", data_o[1]);
        end
    endtask

    task automatic test_clear_collision;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, mk_addr(0, 0), 32'h0, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_addr(0, 2), 32'h1234_5678, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(0, 2), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (data_o[k] !== 32'd1) begin
                n_bad++; $display("FAIL clear_collide[%0d] got %0d want 1", k, data_o[k]);
            end
        end
    endtask

    task automatic test_saturate;
        force dut0.g_ch[3].g_real.drop_cnt = 32'hFFFF_FFFE;
        force dut1.g_ch[3].g_real.drop_cnt = 32'hFFFF_FFFE;
        step(1'b0, 1'b0, 1'b0, 1'b1, mk_addr(0, 0), 32'h0, 4'h0);
        release dut0.g_ch[3].g_real.drop_cnt;
        release dut1.g_ch[3].g_real.drop_cnt;
        m_cnt[0][3] = 64'hFFFF_FFFE;
        m_cnt[1][3] = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, mk_addr(0, 0), 32'h0, 4'b1000);
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(3, 2), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (data_o[k] !== 32'hFFFF_FFFF) begin
                n_bad++; $display("FAIL saturate[%0d] got %h want ffffffff", k, data_o[k]);
            end
        end
    endtask

    task automatic test_bad_ch_info;
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(NCH, 0), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'hdead_beef) begin
                n_bad++; $display("FAIL bad_ch[%0d] ack=%b data=%h want 1 deadbeef", k, ack_o[k], data_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(1, 3), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'd4) begin
                n_bad++; $display("FAIL info[%0d] ack=%b data=%h want 1 4", k, ack_o[k], data_o[k]);
            end
        end
    endtask

    task automatic test_passthrough;
        step(1'b0, 1'b1, 1'b0, 1'b1, {15'h0002, 6'd0, 2'd0}, 32'hCAFE_F00D, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b0 || data_o[k] !== 32'hCAFE_F00D || req_o[k] !== 1'b1) begin
                n_bad++; $display("FAIL tag_miss[%0d] ack=%b data=%h req=%b want 0 cafef00d 1", k, ack_o[k], data_o[k], req_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, mk_addr(0, 0), 32'h0BAD_0001, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'h0BAD_0001 || en_o[k][0] !== 1'b0) begin
                n_bad++; $display("FAIL acked_hit[%0d] ack=%b data=%h en0=%b want 1 0bad0001 0", k, ack_o[k], data_o[k], en_o[k][0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [22:0] a;
        logic [3:0]  exp_en;
        logic [63:0] exp_sh;
        for (int i = 0; i < 400; i++) begin
            a = {(($urandom % 5) == 0) ? 15'h0002 : TAG, 6'($urandom % 6), 2'($urandom)};
            step(($urandom % 50) == 0, ($urandom % 10) < 7, ($urandom % 7) == 0, 1'($urandom),
                 a, $urandom, 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_en[c] = m_en[k][c];
                    exp_sh[16*c +: 16] = m_sh[k][c];
                end
                n_cmp++;
                if (req_o[k] !== e_req || ack_o[k] !== e_ack[k] || data_o[k] !== e_data[k] ||
                    addr_o[k] !== e_addr || src_o[k] !== e_src || rw_o[k] !== e_rw ||
                    en_o[k] !== exp_en || sh_o[k] !== exp_sh) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] cyc %0d req=%b ack=%b data=%h en=%h sh=%h want req=%b ack=%b data=%h en=%h sh=%h",
                             k, i, req_o[k], ack_o[k], data_o[k], en_o[k], sh_o[k], e_req, e_ack[k], e_data[k], exp_en, exp_sh);
                end
            end
        end
    endtask

    task automatic test_reset_write;
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_addr(3, 1), 32'h0000_00AA, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, mk_addr(3, 0), 32'h1, 4'hF);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (req_o[k] !== 1'b0 || ack_o[k] !== 1'b0 || data_o[k] !== 32'h0 || en_o[k] !== 4'h0 || sh_o[k] !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_write[%0d] req=%b ack=%b data=%h en=%h sh=%h want all 0", k, req_o[k], ack_o[k], data_o[k], en_o[k], sh_o[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_addr(3, 0), 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ack_o[k] !== 1'b1 || data_o[k] !== 32'h0) begin
                n_bad++; $display("FAIL reset_write_rd[%0d] ack=%b data=%h want 1 0", k, ack_o[k], data_o[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_drop_count();
        test_clear_collision();
        test_saturate();
        test_bad_ch_info();
        test_passthrough();
        test_back_to_back();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
